// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART core with RX FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned tick_hz;
        tick_hz = baud * oversample;
        return (clk_freq + tick_hz / 2) / tick_hz;
    endfunction

    // Bits needed to hold the values 0..max_val (at least one).
    function automatic int unsigned width_of(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head word; pointers carry a wrap bit.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    // Flags, accepted operations and the head word as seen after this edge.
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        // A push landing in the new read slot means the FIFO was about to be empty.
        if (wr_d == rd_d) begin
            head_d = '0;
        end else if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    assign head_o = head_q;

endmodule

// File: rtl/uart_core_fifo.sv
// Full-duplex UART: shared baud generator, TX FSM, oversampled RX FSM, RX FIFO.
// Define UART_PARITY_EN for an even parity bit on TX/RX and the out_Rx_PE flag.
module uart_core_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned RX_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_w_data,
    input  logic                 in_valid,
    output logic                 out_BUSY,
    output logic                 out_signal,
    input  logic                 in_signal,
    output logic [DATA_BITS-1:0] out_word,
    output logic                 out_RXNE,
    input  logic                 in_RXNE_clear,
    output logic                 out_Rx_ORE,
    output logic                 out_Rx_FE,
    input  logic                 in_err_clear
`ifdef UART_PARITY_EN
    ,
    output logic                 out_Rx_PE
`endif
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = width_of(DIV);
    localparam int unsigned OS_W  = width_of(OVERSAMPLE - 1);
    localparam int unsigned BIT_W = width_of(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_core_fifo: baud divider rounds below 1");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) || (RX_DEPTH < 2) ||
        ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_param
        $error("uart_core_fifo: parameter out of range");
    end

    // ---------------- baud generator ----------------
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             baud_tick;

    // Free-running divider producing a one-cycle oversample tick.
    always_comb begin
        baud_tick  = (baud_cnt_q == DIV_W'(DIV - 1));
        baud_cnt_d = baud_tick ? '0 : baud_cnt_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) baud_cnt_q <= '0;
        else     baud_cnt_q <= baud_cnt_d;
    end

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [OS_W-1:0]      tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 tx_run_q, tx_run_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    // TX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_run_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_run_q   <= tx_run_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // TX next state: START holds the line high until the first tick, then bits last OVERSAMPLE ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_run_d   = tx_run_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q == TX_IDLE) begin
            if (in_valid) begin
                tx_state_d = TX_START;
                tx_shift_d = in_w_data;
                tx_tick_d  = '0;
                tx_bit_d   = '0;
                tx_run_d   = 1'b0;
`ifdef UART_PARITY_EN
                tx_par_d   = ^in_w_data;
`endif
            end
        end else if (baud_tick) begin
            if (!tx_run_q) begin
                tx_run_d  = 1'b1;
                tx_tick_d = '0;
            end else if (tx_tick_q != OS_W'(OVERSAMPLE - 1)) begin
                tx_tick_d = tx_tick_q + OS_W'(1);
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = '0;
                    end
                    TX_DATA: begin
                        if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                            tx_state_d = TX_PARITY;
`else
                            tx_state_d = TX_STOP;
`endif
                        end else begin
                            tx_bit_d   = tx_bit_q + BIT_W'(1);
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end
                    TX_PARITY: tx_state_d = TX_STOP;
                    TX_STOP: begin
                        if (tx_bit_q == BIT_W'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
                        else                                    tx_bit_d   = tx_bit_q + BIT_W'(1);
                    end
                    default: tx_state_d = TX_IDLE;
                endcase
            end
        end
    end

    // TX outputs decoded from registered state.
    always_comb begin
        out_BUSY   = (tx_state_q != TX_IDLE);
        out_signal = 1'b1;
        case (tx_state_q)
            TX_START:  out_signal = ~tx_run_q;
            TX_DATA:   out_signal = tx_shift_q[0];
`ifdef UART_PARITY_EN
            TX_PARITY: out_signal = tx_par_q;
`endif
            default:   out_signal = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_push_q, rx_push_d;
    logic                 fe_set;
`ifdef UART_PARITY_EN
    logic                 pe_set;
    logic                 pe_q;
`endif

    // Two-flop synchroniser plus delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= in_signal;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_push_q  <= rx_push_d;
        end
    end

    // RX next state: mid-start check, then one sample every OVERSAMPLE ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        fe_set     = 1'b0;
`ifdef UART_PARITY_EN
        pe_set     = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = '0;
                end
            end
            RX_START: begin
                if (baud_tick) begin
                    if (rx_tick_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_d = rx_tick_q + OS_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (baud_tick) begin
                    if (rx_tick_q == OS_W'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_d = RX_PARITY;
`else
                            rx_state_d = RX_STOP;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + BIT_W'(1);
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + OS_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (baud_tick) begin
                    if (rx_tick_q == OS_W'(OVERSAMPLE - 1)) begin
                        rx_tick_d  = '0;
                        pe_set     = ^{rx_shift_q, rx_sync_q};
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_tick_d = rx_tick_q + OS_W'(1);
                    end
                end
            end
`endif
            RX_STOP: begin
                if (baud_tick) begin
                    if (rx_tick_q == OS_W'(OVERSAMPLE - 1)) begin
                        rx_tick_d = '0;
                        if (rx_sync_q) begin
                            rx_push_d  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            fe_set     = 1'b1;
                            rx_state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + OS_W'(1);
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO and sticky flags ----------------
    logic fifo_full, fifo_empty;
    logic ore_set;
    logic ore_q, fe_q;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push_q),
        .data_i  (rx_shift_q),
        .pop_i   (in_RXNE_clear),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (out_word)
    );

    // Overrun only when a full FIFO is not popped in the same cycle.
    always_comb begin
        ore_set  = rx_push_q && fifo_full && !in_RXNE_clear;
        out_RXNE = !fifo_empty;
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ore_q <= 1'b0;
            fe_q  <= 1'b0;
`ifdef UART_PARITY_EN
            pe_q  <= 1'b0;
`endif
        end else begin
            ore_q <= ore_set | (ore_q & ~in_err_clear);
            fe_q  <= fe_set  | (fe_q  & ~in_err_clear);
`ifdef UART_PARITY_EN
            pe_q  <= pe_set  | (pe_q  & ~in_err_clear);
`endif
        end
    end

    assign out_Rx_ORE = ore_q;
    assign out_Rx_FE  = fe_q;
`ifdef UART_PARITY_EN
    assign out_Rx_PE  = pe_q;
`endif

endmodule
